sprite_redraw: RTL and testbench
================================

# sprite_redraw

Erase-move-draw sequencer for one square sprite on the 160x120 VGA framebuffer. It sits between the frame timer and the per-axis coordinate counters. On each frame tick it:

- paints the sprite's current square in the background colour;
- pulses the coordinate counters' enable so they step once;
- repaints the square in the sprite colour at the new position.

Its pixel outputs feed the VGA adapter's plot port directly.

## Interface

Parameters:
- SIZE, default 4: sprite side length in pixels; legal range 1..15.
- COLOUR, default 3'b111: sprite colour.
- BG_COLOUR, default 3'b000: erase colour.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset; asynchronous and active-low.
- tick  in  1  frame-advance pulse from the frame timer; level-sampled in IDLE.
- pos_x  in  8  current x from the x coordinate counter.
- pos_y  in  8  current y from the y coordinate counter.
- move_en  out  1  one-cycle enable to both coordinate counters.
- busy  out  1  high in every state except IDLE.
- plot  out  1  framebuffer write strobe.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour.

## Operation

- States: IDLE, ERASE, MOVE, LATCH, DRAW.
- Registers:
  - state;
  - base_x[7:0] and base_y[7:0], the latched sprite origin;
  - dx[3:0] and dy[3:0], the pixel offset inside the square.
- All outputs are Moore, decoded from registered state and counters only. No input-to-output combinational path.
- IDLE:
  - plot=0, move_en=0, busy=0.
  - When tick=1 at a rising edge: base_x<=pos_x, base_y<=pos_y, dx<=0, dy<=0, go to ERASE.
- ERASE:
  - plot=1, colour=BG_COLOUR.
  - x = base_x+dx, truncated to 8 bits (wraps mod 256).
  - y = (base_y+dy)[6:0] (wraps mod 128).
  - Scan is row-major: dx increments each cycle; at dx=SIZE-1, dx<=0 and dy increments.
  - At dx=dy=SIZE-1: dx<=0, dy<=0, go to MOVE.
- MOVE:
  - move_en=1, plot=0, for exactly one cycle.
  - The coordinate counters update on the edge that ends MOVE.
  - Next state LATCH.
- LATCH:
  - plot=0.
  - On the edge ending LATCH: base_x<=pos_x, base_y<=pos_y, go to DRAW.
- DRAW:
  - Identical to ERASE except colour=COLOUR.
  - Last pixel returns to IDLE.
- tick is ignored in every state except IDLE; pulses arriving while busy are dropped, not queued.
- If tick is held high, a new sequence starts on the first edge after returning to IDLE.
- Outside ERASE and DRAW, x, y and colour hold 0.
- Reset, at power-up or mid-sequence:
  - asynchronous assertion forces IDLE immediately;
  - dx, dy, base_x, base_y are cleared to 0;
  - plot, move_en and busy go to 0 within the reset assertion;
  - a partially drawn or erased sprite stays on screen, which is acceptable;
  - if reset lands in MOVE, the pulse is truncated and no further move_en is issued.
- No initial draw after reset. The first tick erases background (harmless), then draws.

## Timing

- Edge E0 is the edge that samples tick=1 in IDLE.
- Cycles counted from E0:
  - ERASE plots S*S pixels starting the cycle after E0, at one pixel per cycle;
  - MOVE is cycle S*S+1;
  - LATCH is cycle S*S+2;
  - DRAW covers cycles S*S+3 through 2*S*S+2;
  - IDLE resumes at cycle 2*S*S+3.
- busy is high for 2*S*S+2 consecutive cycles; for SIZE=4 that is 34.
- move_en is high for exactly one cycle per accepted tick.
- plot is low during MOVE and LATCH, so there are two dead cycles between the erase and draw bursts.
- Throughput: at most one sequence per 2*S*S+3 cycles.
- The frame timer period must exceed this; shorter periods lose ticks by design.

## Test plan

- Reset behaviour: assert resetn=0 mid-DRAW → same cycle, plot=0, busy=0, move_en=0. After release with tick=0 → stays IDLE.
- Basic move, SIZE=4, pos=(10,20), upstream step +1 on x:
  - single tick → 16 plots colour 000 covering x 10..13, y 20..23, row-major;
  - one move_en pulse at cycle 17;
  - 16 plots colour 111 covering x 11..14, y 20..23;
  - busy high for exactly 34 cycles.
- Wrap-around, pos=(254,126) → erase pixels include x=255,0,1 and y=127,0,1 (mod 256/128).
- Dropped ticks: extra tick pulses during ERASE and DRAW → exactly one move_en, and the sequence is unaltered.
- Tick held high for 100 cycles, SIZE=4:
  - back-to-back sequences, each 34 busy cycles separated by one IDLE cycle;
  - 3 move_en pulses in total within the window.
- SIZE=1 → erase 1 pixel, MOVE, LATCH, draw 1 pixel; busy for 4 cycles.

Source files
------------

// File: rtl/sprite_redraw.sv
// sprite_redraw: erase-move-draw sequencer for one square sprite on a 160x120 framebuffer.
// Each accepted tick erases the old square, steps the coordinate counters, then draws the new square.
module sprite_redraw #(
    parameter int         SIZE      = 4,
    parameter logic [2:0] COLOUR    = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic [7:0] pos_x,
    input  logic [7:0] pos_y,
    output logic       move_en,
    output logic       busy,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);
    typedef enum logic [2:0] {IDLE, ERASE, MOVE, LATCH, DRAW} state_t;

    localparam logic [3:0] LAST = 4'(SIZE - 1);

    state_t     r_state;
    logic [7:0] r_base_x;
    logic [7:0] r_base_y;
    logic [3:0] r_dx;
    logic [3:0] r_dy;
    logic       w_row_end;
    logic       w_last;
    logic [7:0] w_sum_y;

    assign w_row_end = r_dx == LAST;
    assign w_last    = w_row_end && r_dy == LAST;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_base_x <= '0;
            r_base_y <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
        end else begin
            case (r_state)
                IDLE: if (tick) begin
                    r_base_x <= pos_x;
                    r_base_y <= pos_y;
                    r_dx     <= '0;
                    r_dy     <= '0;
                    r_state  <= ERASE;
                end
                ERASE, DRAW: begin
                    r_dx <= w_row_end ? 4'd0 : r_dx + 4'd1;
                    r_dy <= w_last ? 4'd0 : w_row_end ? r_dy + 4'd1 : r_dy;
                    if (w_last)
                        r_state <= (r_state == ERASE) ? MOVE : IDLE;
                end
                MOVE: r_state <= LATCH;
                LATCH: begin
                    // counters stepped on the edge that ended MOVE, so pos is already the new origin
                    r_base_x <= pos_x;
                    r_base_y <= pos_y;
                    r_state  <= DRAW;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sum_y = r_base_y + {4'b0, r_dy};
    assign plot    = r_state == ERASE || r_state == DRAW;
    assign move_en = r_state == MOVE;
    assign busy    = r_state != IDLE;
    assign x       = plot ? r_base_x + {4'b0, r_dx} : 8'd0;
    assign y       = plot ? w_sum_y[6:0] : 7'd0;
    assign colour  = r_state == ERASE ? BG_COLOUR : r_state == DRAW ? COLOUR : 3'b000;
endmodule

// File: tb/tb_sprite_redraw.sv
// tb_sprite_redraw: directed and randomized checks of sprite_redraw (SIZE=4 and SIZE=1)
// against a cycle-indexed model of the erase/move/latch/draw timeline.
module tb_sprite_redraw;
    logic       clk = 0;
    logic       resetn = 0;
    logic       tick4 = 0, tick1 = 0;
    logic [7:0] pos_x = 0, pos_y = 0;
    logic       load = 0;
    logic [7:0] lx = 0, ly = 0, stx = 0, sty = 0;
    logic       move_en4, busy4, plot4, move_en1, busy1, plot1;
    logic [7:0] x4, x1;
    logic [6:0] y4, y1;
    logic [2:0] col4, col1;
    logic [20:0] vec4, vec1;
    int mv_count = 0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    sprite_redraw dut4 (.clk(clk), .resetn(resetn), .tick(tick4), .pos_x(pos_x), .pos_y(pos_y),
        .move_en(move_en4), .busy(busy4), .plot(plot4), .x(x4), .y(y4), .colour(col4));
    sprite_redraw #(.SIZE(1)) dut1 (.clk(clk), .resetn(resetn), .tick(tick1), .pos_x(pos_x), .pos_y(pos_y),
        .move_en(move_en1), .busy(busy1), .plot(plot1), .x(x1), .y(y1), .colour(col1));

    assign vec4 = {busy4, move_en4, plot4, x4, y4, col4};
    assign vec1 = {busy1, move_en1, plot1, x1, y1, col1};

    // coordinate counters upstream of the sequencer
    always @(posedge clk) begin
        if (load) begin
            pos_x <= lx;
            pos_y <= ly;
        end else if (move_en4 || move_en1) begin
            pos_x <= pos_x + stx;
            pos_y <= pos_y + sty;
        end
        if (move_en4 || move_en1) mv_count <= mv_count + 1;
    end

    // expected {busy,move_en,plot,x,y,colour} in cycle k after the edge that accepted the tick
    function automatic logic [20:0] exp_vec(input int s, input int k, input int ox, input int oy,
                                            input int nx, input int ny);
        int ss, idx;
        ss = s * s;
        if (k >= 1 && k <= ss) begin
            idx = k - 1;
            return {3'b101, 8'((ox + idx % s) % 256), 7'((oy + idx / s) % 128), 3'b000};
        end
        if (k == ss + 1) return {3'b110, 18'd0};
        if (k == ss + 2) return {3'b100, 18'd0};
        if (k <= 2 * ss + 2) begin
            idx = k - ss - 3;
            return {3'b101, 8'((nx + idx % s) % 256), 7'((ny + idx / s) % 128), 3'b111};
        end
        return 21'd0;
    endfunction

    task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic load_pos(input logic [7:0] ox, input logic [7:0] oy, input logic [7:0] sx, input logic [7:0] sy);
        @(negedge clk);
        load = 1; lx = ox; ly = oy; stx = sx; sty = sy;
        @(negedge clk);
        load = 0;
    endtask

    task automatic run_seq(input bit one, input int s, input logic [7:0] ox, input logic [7:0] oy,
                           input logic [7:0] sx, input logic [7:0] sy, input bit extra);
        int nx, ny, mv0;
        logic t;
        load_pos(ox, oy, sx, sy);
        if (one) tick1 = 1; else tick4 = 1;
        mv0 = mv_count;
        nx = (int'(ox) + int'(sx)) % 256;
        ny = (int'(oy) + int'(sy)) % 256;
        for (int k = 1; k <= 2 * s * s + 3; k++) begin
            @(negedge clk);
            check(one ? "seq1" : "seq4", one ? vec1 : vec4, exp_vec(s, k, ox, oy, nx, ny));
            t = extra && (k == 3 || k == s * s + 6);
            if (one) tick1 = t; else tick4 = t;
        end
        check("move_count", 21'(mv_count - mv0), 21'd1);
    endtask

    initial begin
        int mv0;
        @(negedge clk);
        check("reset4", vec4, 21'd0);
        check("reset1", vec1, 21'd0);
        resetn = 1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", vec4, 21'd0);

        run_seq(0, 4, 8'd10, 8'd20, 8'd1, 8'd0, 0);
        run_seq(0, 4, 8'd254, 8'd126, 8'd3, 8'd5, 0);
        run_seq(0, 4, 8'd40, 8'd60, 8'd255, 8'd2, 1);
        for (int i = 0; i < 4; i++)
            run_seq(0, 4, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i[0]);
        run_seq(1, 1, 8'd100, 8'd127, 8'd1, 8'd1, 0);
        run_seq(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);

        // reset asserted mid-DRAW
        load_pos(8'd30, 8'd30, 8'd1, 8'd1);
        tick4 = 1;
        @(negedge clk);
        tick4 = 0;
        repeat (20) @(negedge clk);
        check("in_draw", {vec4[20:18]}, 21'b101);
        resetn = 0;
        #1;
        check("reset_mid_draw", vec4, 21'd0);
        @(negedge clk);
        resetn = 1;
        repeat (3) @(negedge clk);
        check("idle_after_draw_reset", vec4, 21'd0);

        // reset asserted during MOVE truncates the pulse
        load_pos(8'd50, 8'd50, 8'd1, 8'd1);
        tick4 = 1;
        @(negedge clk);
        tick4 = 0;
        repeat (16) @(negedge clk);
        check("in_move", vec4, {3'b110, 18'd0});
        mv0 = mv_count;
        resetn = 0;
        #1;
        check("reset_mid_move", vec4, 21'd0);
        @(negedge clk);
        resetn = 1;
        repeat (5) @(negedge clk);
        check("no_move_after_reset", 21'(mv_count - mv0), 21'd0);

        // tick held high: back-to-back sequences 35 cycles apart
        load_pos(8'd5, 8'd5, 8'd2, 8'd0);
        mv0 = mv_count;
        tick4 = 1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check("held", {19'd0, busy4, move_en4}, {19'd0, k % 35 != 0, k % 35 == 17});
        end
        tick4 = 0;
        check("held_moves", 21'(mv_count - mv0), 21'd3);
        repeat (10) @(negedge clk);
        check("held_idle", vec4, 21'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
